// File: rtl/dmem_arbiter_if.sv
// Requester-side channel of the data-memory arbiter: valid/ready request plus
// the fixed-latency read response returned to the same requester.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 14
);
   logic              valid_in;
   logic              ready_out;
   logic [ADDR_W-1:0] addr_in;
   logic [31:0]       wdata_in;
   logic [3:0]        we_in;
   logic              rsp_valid_out;
   logic [31:0]       rsp_data_out;

   modport master (
      output valid_in, addr_in, wdata_in, we_in,
      input  ready_out, rsp_valid_out, rsp_data_out
   );

   modport slave (
      input  valid_in, addr_in, wdata_in, we_in,
      output ready_out, rsp_valid_out, rsp_data_out
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single BRAM port; reads are
// tracked by a tag pipe so each response returns to the port that issued it.
module dmem_arbiter #(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   dmem_arbiter_if.slave     req0,
   dmem_arbiter_if.slave     req1,
   output logic              mem_en_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [31:0]       mem_data_out,
   output logic [3:0]        mem_we_out,
   input  logic [31:0]       mem_data_in
);

   logic        prio_q;
   logic        valid0_c;
   logic        valid1_c;
   logic        grant0_c;
   logic        grant1_c;
   logic        push_vld_c;
   logic        push_id_c;
   logic        tail_vld_c;
   logic        tail_id_c;
   logic        rsp0_valid_q;
   logic        rsp1_valid_q;
   logic [31:0] rsp0_data_q;
   logic [31:0] rsp1_data_q;

   // Requests are masked during reset so nothing reaches the BRAM
   always_comb begin
      valid0_c = req0.valid_in & rst_n_in;
      valid1_c = req1.valid_in & rst_n_in;
      grant0_c = valid0_c & (~valid1_c | ~prio_q);
      grant1_c = valid1_c & (~valid0_c | prio_q);
   end

   assign req0.ready_out = grant0_c;
   assign req1.ready_out = grant1_c;

   always_comb begin
      mem_en_out   = grant0_c | grant1_c;
      mem_addr_out = req0.addr_in;
      mem_data_out = req0.wdata_in;
      mem_we_out   = 4'b0000;
      if (grant1_c) begin
         mem_addr_out = req1.addr_in;
         mem_data_out = req1.wdata_in;
         mem_we_out   = req1.we_in;
      end else if (grant0_c) begin
         mem_we_out   = req0.we_in;
      end
      push_vld_c = (grant0_c && (req0.we_in == 4'b0000)) ||
                   (grant1_c && (req1.we_in == 4'b0000));
      push_id_c  = grant1_c;
   end

   // Tie-break pointer flips only on contention, handing the next tie to the loser
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         prio_q <= 1'b0;
      end else if (valid0_c && valid1_c) begin
         prio_q <= ~prio_q;
      end
   end

   // The response registers form the last stage, so only READ_LATENCY-1 tag stages precede them
   if (READ_LATENCY == 1) begin : g_no_pipe
      assign tail_vld_c = push_vld_c;
      assign tail_id_c  = push_id_c;
   end else begin : g_pipe
      localparam int unsigned DEPTH = READ_LATENCY - 1;
      logic [DEPTH-1:0] vld_q;
      logic [DEPTH-1:0] id_q;

      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            vld_q <= '0;
            id_q  <= '0;
         end else begin
            vld_q[0] <= push_vld_c;
            id_q[0]  <= push_id_c;
            for (int i = 1; i < int'(DEPTH); i++) begin
               vld_q[i] <= vld_q[i-1];
               id_q[i]  <= id_q[i-1];
            end
         end
      end

      assign tail_vld_c = vld_q[DEPTH-1];
      assign tail_id_c  = id_q[DEPTH-1];
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= 32'h0;
         rsp1_data_q  <= 32'h0;
      end else begin
         rsp0_valid_q <= tail_vld_c & ~tail_id_c;
         rsp1_valid_q <= tail_vld_c & tail_id_c;
         if (tail_vld_c && !tail_id_c) rsp0_data_q <= mem_data_in;
         if (tail_vld_c && tail_id_c)  rsp1_data_q <= mem_data_in;
      end
   end

   assign req0.rsp_valid_out = rsp0_valid_q;
   assign req0.rsp_data_out  = rsp0_data_q;
   assign req1.rsp_valid_out = rsp1_valid_q;
   assign req1.rsp_data_out  = rsp1_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   localparam int unsigned ADDR_W = 14;
   localparam int unsigned RL     = 2;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic              mem_en_out;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [31:0]       mem_data_out;
   logic [3:0]        mem_we_out;
   logic [31:0]       mem_data_in;

   dmem_arbiter_if #(.ADDR_W(ADDR_W)) req0 ();
   dmem_arbiter_if #(.ADDR_W(ADDR_W)) req1 ();

   dmem_arbiter #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .req0         (req0),
      .req1         (req1),
      .mem_en_out   (mem_en_out),
      .mem_addr_out (mem_addr_out),
      .mem_data_out (mem_data_out),
      .mem_we_out   (mem_we_out),
      .mem_data_in  (mem_data_in)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] init_word(input int unsigned a);
      if (a == 32'h10) return 32'hDEADBEEF;
      if (a == 32'h20) return 32'hAAAAAAAA;
      return 32'(a) * 32'h9E3779B9;
   endfunction

   // BRAM stand-in: registered read-first port, so data is on mem_data_in one cycle after the address
   logic [31:0] bram [DEPTH];
   logic [31:0] mem_rd_q;
   assign mem_data_in = mem_rd_q;
   initial begin : bram_model
      logic [31:0] w;
      for (int i = 0; i < int'(DEPTH); i++) bram[i] = init_word(i);
      mem_rd_q = 32'h0;
      forever begin
         @(posedge clk_in);
         if (mem_en_out === 1'b1) begin
            w = bram[mem_addr_out];
            mem_rd_q <= w;
            for (int b = 0; b < 4; b++)
               if (mem_we_out[b]) w[8*b +: 8] = mem_data_out[8*b +: 8];
            bram[mem_addr_out] = w;
         end
      end
   end

   // Reference model: memory image, tie-break owner, and queue of due responses
   typedef struct {
      int          due;
      bit          port;
      logic [31:0] data;
   } rsp_t;

   logic [31:0] ref_mem [DEPTH];
   rsp_t        pend [$];
   bit          m_prio;
   bit          m_g0;
   bit          m_g1;
   int          cyc     = 0;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic check_cycle();
      bit                v0, v1, g0, g1, e0, e1;
      logic [31:0]       d0, d1, ed, w;
      logic [ADDR_W-1:0] ea;
      logic [3:0]        ew;
      rsp_t              r;
      if (rst_n_in !== 1'b1) begin
         pend.delete();
         m_prio = 1'b0;
         m_g0   = 1'b0;
         m_g1   = 1'b0;
         chk("rst_ready0",  32'(req0.ready_out), 32'h0);
         chk("rst_ready1",  32'(req1.ready_out), 32'h0);
         chk("rst_mem_en",  32'(mem_en_out), 32'h0);
         chk("rst_mem_we",  32'(mem_we_out), 32'h0);
         chk("rst_rsp0_v",  32'(req0.rsp_valid_out), 32'h0);
         chk("rst_rsp1_v",  32'(req1.rsp_valid_out), 32'h0);
         chk("rst_rsp0_d",  req0.rsp_data_out, 32'h0);
         chk("rst_rsp1_d",  req1.rsp_data_out, 32'h0);
         return;
      end
      v0 = req0.valid_in;
      v1 = req1.valid_in;
      if (v0 && v1) begin
         g0 = (m_prio == 1'b0);
         g1 = !g0;
      end else begin
         g0 = v0;
         g1 = v1;
      end
      chk("ready0", 32'(req0.ready_out), 32'(g0));
      chk("ready1", 32'(req1.ready_out), 32'(g1));
      chk("mem_en", 32'(mem_en_out), 32'(g0 | g1));
      if (g0 || g1) begin
         ea = g1 ? req1.addr_in  : req0.addr_in;
         ew = g1 ? req1.we_in    : req0.we_in;
         ed = g1 ? req1.wdata_in : req0.wdata_in;
         chk("mem_addr", 32'(mem_addr_out), 32'(ea));
         chk("mem_we",   32'(mem_we_out), 32'(ew));
         if (ew != 4'b0000) begin
            chk("mem_wdata", mem_data_out, ed);
            w = ref_mem[ea];
            for (int b = 0; b < 4; b++) if (ew[b]) w[8*b +: 8] = ed[8*b +: 8];
            ref_mem[ea] = w;
         end else begin
            r.due  = cyc + int'(RL);
            r.port = g1;
            r.data = ref_mem[ea];
            pend.push_back(r);
         end
      end else begin
         chk("idle_mem_we", 32'(mem_we_out), 32'h0);
      end
      e0 = 1'b0; e1 = 1'b0; d0 = 32'h0; d1 = 32'h0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         r = pend.pop_front();
         if (r.port) begin e1 = 1'b1; d1 = r.data; end
         else        begin e0 = 1'b1; d0 = r.data; end
      end
      chk("rsp0_valid", 32'(req0.rsp_valid_out), 32'(e0));
      chk("rsp1_valid", 32'(req1.rsp_valid_out), 32'(e1));
      if (e0) chk("rsp0_data", req0.rsp_data_out, d0);
      if (e1) chk("rsp1_data", req1.rsp_data_out, d1);
      if (v0 && v1) m_prio = !m_prio;
      m_g0 = g0;
      m_g1 = g1;
   endtask

   task automatic tick();
      @(negedge clk_in);
      check_cycle();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic drive(input bit port, input bit v, input int unsigned a,
                        input logic [31:0] d, input logic [3:0] we);
      if (port) begin
         req1.valid_in = v; req1.addr_in = ADDR_W'(a); req1.wdata_in = d; req1.we_in = we;
      end else begin
         req0.valid_in = v; req0.addr_in = ADDR_W'(a); req0.wdata_in = d; req0.we_in = we;
      end
   endtask

   task automatic new_rand(input bit port);
      logic [3:0] we;
      we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      drive(port, $urandom_range(0, 3) != 0, 32'h40 + $urandom_range(0, 15), $urandom, we);
   endtask

   typedef struct {
      logic              v0;
      logic              v1;
      logic              r0;
      logic              r1;
      logic [ADDR_W-1:0] addr;
   } arb_vec_t;

   arb_vec_t vec [10];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      int          cnt;
      logic [31:0] seen;
      // Ties alternate starting with port 0; a lone requester leaves the pointer alone
      vec[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 14'h001};
      vec[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 14'h002};
      vec[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 14'h001};
      vec[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 14'h002};
      vec[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 14'h002};
      vec[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 14'h001};
      vec[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 14'h001};
      vec[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 14'h002};
      vec[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 14'h000};
      vec[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 14'h002};
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
      m_prio = 1'b0;

      // Reset held with both requesters valid
      rst_n_in = 1'b0;
      drive(0, 1'b1, 32'h001, 32'h0, 4'b0000);
      drive(1, 1'b1, 32'h002, 32'h0, 4'b0000);
      repeat (3) tick();
      rst_n_in = 1'b1;

      // Arbitration table, starting from the reset pointer
      for (int i = 0; i < 10; i++) begin
         req0.valid_in = vec[i].v0;
         req1.valid_in = vec[i].v1;
         #2;
         chk($sformatf("tbl%0d_ready0", i), 32'(req0.ready_out), 32'(vec[i].r0));
         chk($sformatf("tbl%0d_ready1", i), 32'(req1.ready_out), 32'(vec[i].r1));
         if (vec[i].r0 || vec[i].r1)
            chk($sformatf("tbl%0d_addr", i), 32'(mem_addr_out), 32'(vec[i].addr));
         tick();
      end
      drive(0, 1'b0, 0, 32'h0, 4'b0000);
      drive(1, 1'b0, 0, 32'h0, 4'b0000);
      repeat (3) tick();

      // Single read from port 0
      drive(0, 1'b1, 32'h010, 32'h0, 4'b0000);
      #2;
      chk("rd_ready0", 32'(req0.ready_out), 32'h1);
      chk("rd_addr", 32'(mem_addr_out), 32'h010);
      tick();
      drive(0, 1'b0, 0, 32'h0, 4'b0000);
      #2;
      chk("rd_early_rsp0", 32'(req0.rsp_valid_out), 32'h0);
      tick();
      #2;
      chk("rd_rsp0_valid", 32'(req0.rsp_valid_out), 32'h1);
      chk("rd_rsp0_data", req0.rsp_data_out, 32'hDEADBEEF);
      chk("rd_rsp1_quiet", 32'(req1.rsp_valid_out), 32'h0);
      tick();
      #2;
      chk("rd_rsp0_single", 32'(req0.rsp_valid_out), 32'h0);
      tick();

      // Partial write from port 1, then read back from port 0
      drive(1, 1'b1, 32'h020, 32'h12345678, 4'b0011);
      #2;
      chk("wr_ready1", 32'(req1.ready_out), 32'h1);
      tick();
      drive(1, 1'b0, 0, 32'h0, 4'b0000);
      drive(0, 1'b1, 32'h020, 32'h0, 4'b0000);
      tick();
      drive(0, 1'b0, 0, 32'h0, 4'b0000);
      #2;
      chk("wr_no_rsp1", 32'(req1.rsp_valid_out), 32'h0);
      tick();
      #2;
      chk("wr_rb_valid", 32'(req0.rsp_valid_out), 32'h1);
      chk("wr_rb_data", req0.rsp_data_out, 32'hAAAA5678);
      tick();
      repeat (2) tick();

      // Eight back-to-back reads from port 1
      seen = 32'h0;
      for (int k = 0; k < 11; k++) begin
         drive(1, k < 8, 32'h100 + k, 32'h0, 4'b0000);
         #2;
         if (req1.rsp_valid_out === 1'b1) seen[k] = 1'b1;
         tick();
      end
      chk("b2b_pulses", seen, 32'h000003FC);

      // Reset with two reads in flight
      drive(0, 1'b1, 32'h001, 32'h0, 4'b0000);
      tick();
      drive(0, 1'b0, 0, 32'h0, 4'b0000);
      drive(1, 1'b1, 32'h002, 32'h0, 4'b0000);
      tick();
      drive(1, 1'b0, 0, 32'h0, 4'b0000);
      rst_n_in = 1'b0;
      tick();
      rst_n_in = 1'b1;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         #2;
         if (req0.rsp_valid_out === 1'b1) cnt++;
         if (req1.rsp_valid_out === 1'b1) cnt++;
         tick();
      end
      chk("flush_no_rsp", 32'(cnt), 32'h0);
      drive(0, 1'b1, 32'h003, 32'h0, 4'b0000);
      drive(1, 1'b1, 32'h004, 32'h0, 4'b0000);
      #2;
      chk("flush_prio_r0", 32'(req0.ready_out), 32'h1);
      chk("flush_prio_r1", 32'(req1.ready_out), 32'h0);
      tick();
      drive(0, 1'b0, 0, 32'h0, 4'b0000);
      drive(1, 1'b0, 0, 32'h0, 4'b0000);
      repeat (3) tick();

      // Random traffic; a request is held stable until it is accepted
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!req0.valid_in || m_g0) new_rand(0);
         if (!req1.valid_in || m_g1) new_rand(1);
         tick();
      end
      drive(0, 1'b0, 0, 32'h0, 4'b0000);
      drive(1, 1'b0, 0, 32'h0, 4'b0000);
      repeat (4) tick();
      chk("drain_empty", 32'(pend.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
